count_seg7_display: RTL and testbench

- Downstream consumer of the 4-bit down counter (15..0). Drives the Nexys2 4-digit multiplexed seven-segment display.
- Shows the count as a decimal value 0..15 on the two rightmost digits. The leading zero is blanked and the two left digits are always off.
- The displayed value updates only at scan-frame boundaries, so no digit tears mid-frame.
- Includes per-slot anode blanking to suppress ghosting.

---
 rtl/count_seg7_display_if.sv | 11 +
 rtl/count_seg7_display.sv | 106 ++++++++++
 tb/tb_count_seg7_display.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/count_seg7_display_if.sv
// Bundle between the down counter and the seven-segment display driver:
// the count travels in, the anode/cathode/decimal-point drive travels out.
interface count_seg7_display_if;
    logic [3:0] count;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (output count, input an, input seg, input dp);
    modport slave  (input count, output an, output seg, output dp);
endinterface

// File: rtl/count_seg7_display.sv
// Multiplexed 4-digit seven-segment driver showing a 0..15 count as decimal on
// the two right digits, with frame-aligned value capture and per-slot blanking.
module count_seg7_display #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                 clk,
    input  logic                 reset,
    count_seg7_display_if.slave  bus
);

    localparam int            PW        = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PCNT_MAX  = PW'(SCAN_DIV - 1);
    localparam bit            BLANK_EN  = (BLANK_CYCLES > 0);
    localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYCLES);

    logic [PW-1:0] pcnt_q,   pcnt_d;
    logic [1:0]    idx_q,    idx_d;
    logic [3:0]    shadow_q, shadow_d;
    logic [3:0]    an_q,     an_d;
    logic [6:0]    seg_q,    seg_d;

    logic       tick;
    logic       tens;
    logic [3:0] units;
    logic       blank;
    logic [3:0] digit;
    logic       digit_en;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        digit    = 4'd0;
        digit_en = 1'b0;
        an_d     = 4'b1111;
        seg_d    = 7'b1111111;

        tick     = (pcnt_q == PCNT_MAX);
        pcnt_d   = tick ? '0 : pcnt_q + PW'(1);
        idx_d    = tick ? idx_q + 2'd1 : idx_q;
        // Capture only on the last edge of slot 3 so a frame never mixes two values.
        shadow_d = (tick && idx_q == 2'd3) ? bus.count : shadow_q;

        tens  = (shadow_q >= 4'd10);
        units = tens ? shadow_q - 4'd10 : shadow_q;
        blank = BLANK_EN && (pcnt_q < BLANK_LIM);

        case (idx_q)
            2'd0: begin
                digit    = units;
                digit_en = 1'b1;
            end
            2'd1: begin
                digit    = 4'd1;
                digit_en = tens;
            end
            default: begin
                digit    = 4'd0;
                digit_en = 1'b0;
            end
        endcase

        if (!blank && digit_en) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = seg_decode(digit);
        end
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q   <= '0;
            idx_q    <= 2'd0;
            shadow_q <= 4'd0;
            an_q     <= 4'b1111;
            seg_q    <= 7'b1111111;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            pcnt_q   <= pcnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_count_seg7_display.sv
// Scoreboard bench for count_seg7_display: each frame's latched count is queued
// and checked slot by slot against the following frame's display.
module tb_count_seg7_display;

    localparam int SCAN_DIV     = 4;
    localparam int BLANK_CYCLES = 1;
    localparam int FRAME        = 4 * SCAN_DIV;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic       clk;
    logic       reset;
    logic [3:0] count;

    int checks;
    int errors;

    logic [3:0] exp_q [$];

    count_seg7_display_if dut_if ();
    assign dut_if.count = count;

    count_seg7_display #(
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame (c0 in slot 0, c1 from slot 1, c2 on the latch edge),
    // checks the displayed value queued by the previous frame, and queues c2.
    // abort_at < FRAME asserts reset at that cycle and restarts the scoreboard.
    task automatic run_frame(input logic [3:0] c0, input logic [3:0] c1,
                             input logic [3:0] c2, input int abort_at, input string tag);
        logic [3:0] shown;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int         slot;
        int         pos;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard_empty actual=0 required=1 entries", tag);
            shown = 4'd0;
        end else begin
            shown = exp_q.pop_front();
        end
        for (int j = 0; j < FRAME; j++) begin
            if (j == abort_at) begin
                reset = 1'b1;
                step();
                checks++;
                if (dut_if.an !== 4'b1111) begin
                    errors++;
                    $display("FAIL %s reset_mid_an actual=%b required=1111", tag, dut_if.an);
                end
                checks++;
                if (dut_if.seg !== 7'b1111111) begin
                    errors++;
                    $display("FAIL %s reset_mid_seg actual=%b required=1111111", tag, dut_if.seg);
                end
                reset = 1'b0;
                exp_q.delete();
                exp_q.push_back(4'd0);
                return;
            end
            count = (j < SCAN_DIV) ? c0 : (j < FRAME - 1) ? c1 : c2;
            step();
            slot    = j / SCAN_DIV;
            pos     = j % SCAN_DIV;
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
            if (pos >= BLANK_CYCLES) begin
                if (slot == 0) begin
                    exp_an  = 4'b1110;
                    exp_seg = SEG_TAB[int'(shown) % 10];
                end else if (slot == 1 && shown >= 4'd10) begin
                    exp_an  = 4'b1101;
                    exp_seg = SEG_TAB[1];
                end
            end
            checks++;
            if (dut_if.an !== exp_an) begin
                errors++;
                $display("FAIL %s an value=%0d slot=%0d pos=%0d actual=%b required=%b",
                         tag, shown, slot, pos, dut_if.an, exp_an);
            end
            checks++;
            if (dut_if.seg !== exp_seg) begin
                errors++;
                $display("FAIL %s seg value=%0d slot=%0d pos=%0d actual=%b required=%b",
                         tag, shown, slot, pos, dut_if.seg, exp_seg);
            end
            checks++;
            if (dut_if.dp !== 1'b1) begin
                errors++;
                $display("FAIL %s dp slot=%0d pos=%0d actual=%b required=1", tag, slot, pos, dut_if.dp);
            end
        end
        exp_q.push_back(c2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        count = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dut_if.an !== 4'b1111) begin
                errors++;
                $display("FAIL reset_an cycle=%0d actual=%b required=1111", i, dut_if.an);
            end
            checks++;
            if (dut_if.seg !== 7'b1111111) begin
                errors++;
                $display("FAIL reset_seg cycle=%0d actual=%b required=1111111", i, dut_if.seg);
            end
            checks++;
            if (dut_if.dp !== 1'b1) begin
                errors++;
                $display("FAIL reset_dp cycle=%0d actual=%b required=1", i, dut_if.dp);
            end
        end
        reset = 1'b0;
        exp_q.delete();
        exp_q.push_back(4'd0);
        run_frame(4'hF, 4'hF, 4'hF, FRAME, "reset_first_frame");
    endtask

    task automatic test_frame_latch();
        run_frame(4'hF, 4'hF, 4'hF, FRAME, "latch_15_a");
        run_frame(4'hF, 4'hF, 4'hF, FRAME, "latch_15_b");
    endtask

    task automatic test_leading_zero();
        run_frame(4'd9,  4'd9,  4'd9,  FRAME, "lz_enter_9");
        run_frame(4'd10, 4'd10, 4'd10, FRAME, "lz_show_9");
        run_frame(4'd10, 4'd10, 4'd10, FRAME, "lz_show_10");
    endtask

    task automatic test_mid_frame();
        run_frame(4'd7, 4'd6, 4'd5, FRAME, "mid_change");
        run_frame(4'd5, 4'd5, 4'd5, FRAME, "mid_show_5");
    endtask

    task automatic test_reset_mid_frame();
        run_frame(4'd12, 4'd12, 4'd12, FRAME, "rmid_load_12");
        // Cycle 10 of the frame is idx=2, pcnt=2.
        run_frame(4'd12, 4'd12, 4'd12, 2 * SCAN_DIV + 2, "rmid_abort");
        run_frame(4'd3, 4'd3, 4'd3, FRAME, "rmid_restart");
        run_frame(4'd3, 4'd3, 4'd3, FRAME, "rmid_show_3");
    endtask

    task automatic test_full_sweep();
        for (int v = 15; v >= 0; v--) begin
            run_frame(4'(v), 4'(v), 4'(v), FRAME, $sformatf("sweep_%0d", v));
        end
        run_frame(4'hF, 4'hF, 4'hF, FRAME, "sweep_wrap_load");
        run_frame(4'hF, 4'hF, 4'hF, FRAME, "sweep_wrap_15");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        count  = 4'hF;
        test_reset();
        test_frame_latch();
        test_leading_zero();
        test_mid_frame();
        test_reset_mid_frame();
        test_full_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
